// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide retire one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_upper;
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] fast_prod;
    logic [2*WIDTH-1:0] mul_result;

    assign op_signed = ~op[0];
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Single-cycle product, only used when FAST_MUL is set.
    assign fast_prod = (op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a})
                     * (op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b});

    // Multiply step: conditionally add multiplicand into the upper half, shift right.
    assign mul_upper   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                       + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Divide step: shift next dividend bit into the remainder and trial-subtract.
    assign div_shifted = {rem_q, acc_q[WIDTH-1]};
    assign div_trial   = div_shifted - {1'b0, opb_q};
    assign mul_result  = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op[2:1])
                        2'b00: begin
                            if (FAST_MUL) begin
                                {hi_d, lo_d} = fast_prod;
                                done_d       = 1'b1;
                            end else begin
                                state_d  = RUN;
                                cnt_d    = '0;
                                acc_d    = {{WIDTH{1'b0}}, b_mag};
                                opb_d    = a_mag;
                                neg_d    = a_neg ^ b_neg;
                                is_div_d = 1'b0;
                                dz_d     = 1'b0;
                            end
                        end
                        2'b01: begin
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (b == '0) begin
                                // Nothing to iterate: report the fault on the next edge.
                                state_d = FINISH;
                                dz_d    = 1'b1;
                            end else begin
                                state_d   = RUN;
                                acc_d     = {{WIDTH{1'b0}}, a_mag};
                                rem_d     = '0;
                                opb_d     = b_mag;
                                neg_d     = a_neg ^ b_neg;
                                rem_neg_d = a_neg;
                                dz_d      = 1'b0;
                            end
                        end
                        2'b10: begin
                            if (op[0]) lo_d = a;
                            else       hi_d = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!div_trial[WIDTH]) begin
                            rem_d = div_trial[WIDTH-1:0];
                            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = div_shifted[WIDTH-1:0];
                            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_upper, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    dbz_d  = dz_q;
                    if (!dz_q) begin
                        if (is_div_q) begin
                            lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                            hi_d = rem_neg_q ? -rem_q : rem_q;
                        end else begin
                            {hi_d, lo_d} = mul_result;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written corner sequences.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          busy1;
        int          bcnt;
        bit          dz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op from a negedge and observe it until done (bounded).
    task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         output int lat, output bit b1, output int bcnt,
                         output bit dz, output bit stable);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; bcnt = 0; stable = 1'b1; b1 = busy; dz = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin
                lat = n - 1;
                dz  = div_by_zero;
                break;
            end
            if (n > 1 && busy) bcnt++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
        end
    endtask

    initial begin
        int lat, bcnt;
        bit b1, dz, stable, seen;
        logic [31:0] h0, l0;

        vecs[0]  = '{3'b001, 32'd123,        32'd456,        32'h0,        32'h0000DB18, 33, 1'b1, 32, 1'b0};
        vecs[1]  = '{3'b000, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1, 33, 1'b1, 32, 1'b0};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 33, 1'b1, 32, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1, 32, 1'b0};
        vecs[4]  = '{3'b011, 32'd100,        32'd7,          32'd2,        32'd14,       33, 1'b1, 32, 1'b0};
        vecs[5]  = '{3'b010, 32'h80000000,   32'hFFFFFFFF,   32'h0,        32'h80000000, 33, 1'b1, 32, 1'b0};
        vecs[6]  = '{3'b000, 32'h80000000,   32'h80000000,   32'h40000000, 32'h0,        33, 1'b1, 32, 1'b0};
        vecs[7]  = '{3'b010, 32'd7,          32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD, 33, 1'b1, 32, 1'b0};
        vecs[8]  = '{3'b100, 32'hDEADBEEF,   32'd0,          32'hDEADBEEF, 32'hFFFFFFFD, 0,  1'b0, 0,  1'b0};
        vecs[9]  = '{3'b101, 32'h55,         32'd0,          32'hDEADBEEF, 32'h55,       0,  1'b0, 0,  1'b0};
        vecs[10] = '{3'b011, 32'd5,          32'd0,          32'hDEADBEEF, 32'h55,       1,  1'b1, 0,  1'b1};

        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, b1, bcnt, dz, stable);
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d dz=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, lat, dz);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy1", i), b1, vecs[i].busy1);
            chk($sformatf("v%0d_busycnt", i), bcnt, vecs[i].bcnt);
            chk($sformatf("v%0d_dz", i), dz, vecs[i].dz);
            chk($sformatf("v%0d_stable", i), stable, 1);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {done, div_by_zero}, 0);
        end

        // Start while busy is ignored.
        start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        op = 3'b101; a = 32'd1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        $display("busy_start: hi=%h lo=%h done=%0d", hi, lo, seen);
        chk("busy_start_done", seen, 1);
        chk("busy_start_lo", lo, 32'd12);
        chk("busy_start_hi", hi, 32'd0);
        @(negedge clk);

        // Flush ten cycles into a DIV.
        h0 = hi; l0 = lo;
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        $display("flush: busy=%0d done_seen=%0d hi=%h lo=%h", busy, seen, hi, lo);
        chk("flush_no_done", seen, 0);
        chk("flush_hi", hi, h0);
        chk("flush_lo", lo, l0);

        // Flush together with start in IDLE: the start wins.
        start = 1'b1; flush = 1'b1; op = 3'b101; a = 32'h77;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        $display("flush_start: done=%0d lo=%h", done, lo);
        chk("flush_start_done", done, 1);
        chk("flush_start_lo", lo, 32'h77);

        // Reserved op is ignored.
        @(negedge clk);
        h0 = hi; l0 = lo;
        start = 1'b1; op = 3'b110; a = 32'hFFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        $display("reserved: activity=%0d hi=%h lo=%h", seen, hi, lo);
        chk("reserved_quiet", seen, 0);
        chk("reserved_hilo", {hi, lo}, {h0, l0});

        // Asynchronous reset mid-RUN.
        start = 1'b1; op = 3'b001; a = 32'd9; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("async_reset: hi=%h lo=%h busy=%0d done=%0d", hi, lo, busy, done);
        chk("areset_hilo", {hi, lo}, 0);
        chk("areset_busy_done", {busy, done}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(3'b101, 32'h1234, 32'd0, lat, b1, bcnt, dz, stable);
        $display("post_reset MTLO: lo=%h lat=%0d", lo, lat);
        chk("post_reset_lo", lo, 32'h1234);
        chk("post_reset_lat", lat, 0);

        // A start in the done cycle is accepted.
        start = 1'b1; op = 3'b100; a = 32'hABCD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        $display("back_to_back: done=%0d hi=%h lo=%h", done, hi, lo);
        chk("b2b_done", done, 1);
        chk("b2b_hi", hi, 32'hABCD);
        chk("b2b_lo", lo, 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
